iter_div_unit: RTL and testbench

- Multi-cycle integer divider for DIV/DIVU in the 54-instruction CPU.
- Sits directly downstream of the register file: dividend and divisor come from the regfile read ports (rs, rt).
- Quotient and remainder are written into LO and HI by the control path.
- Restoring radix-2 algorithm, one quotient bit per cycle; stalls the pipeline via busy.

---
 rtl/cpu54_pkg.sv | 17 +
 rtl/div_step.sv | 26 ++
 rtl/iter_div_unit.sv | 130 +++++++++++++
 tb/tb_iter_div_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu54_pkg.sv
// Shared CPU-wide definitions: datapath width, divider FSM states and the
// DIV/DIVU function codes the control path uses to launch the divider.
package cpu54_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // R-type funct field values that select the divider and its signedness
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration: shift {rem,quo} left, trial-subtract
// the divisor magnitude, keep the difference and set the quotient bit if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_dvs});
  // When the trial fits the true difference is below the divisor (or equals the
  // truncated shift for a zero divisor), so the low WIDTH bits are exact.
  assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;

  assign o_rem = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU, results to LO (quotient) / HI (remainder).
// Optional macro DIV_ZERO_FAST_EN: zero divisor short-circuits to FIN and raises div_zero.
module iter_div_unit
  import cpu54_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_a_neg = is_signed & dividend[WIDTH-1];
  assign w_b_neg = is_signed & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

`ifdef DIV_ZERO_FAST_EN
  logic r_dz;
  logic r_div_zero;
  assign div_zero = r_div_zero;
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
`ifdef DIV_ZERO_FAST_EN
      r_dz        <= 1'b0;
      r_div_zero  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_sign_q <= w_a_neg ^ w_b_neg;
            r_sign_r <= w_a_neg;
            r_cnt    <= CNT_W'(WIDTH);
            r_busy   <= 1'b1;
            r_state  <= CALC;
`ifdef DIV_ZERO_FAST_EN
            r_div_zero <= 1'b0;
            r_dz       <= (divisor == '0);
            // Zero divisor: results are fixed, so skip the iterations entirely
            if (divisor == '0) begin
              r_quo    <= '1;
              r_rem    <= dividend;
              r_sign_q <= 1'b0;
              r_sign_r <= 1'b0;
              r_state  <= FIN;
            end
`endif
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= FIN;
        end
        FIN: begin
          r_quotient  <= r_sign_q ? (~r_quo + 1'b1) : r_quo;
          r_remainder <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
`ifdef DIV_ZERO_FAST_EN
          r_div_zero  <= r_dz;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_iter_div_unit.sv
// Randomized self-checking bench for iter_div_unit against an arithmetic reference model.
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  wire         busy;
  wire         done;
  wire         div_zero;
  wire  [31:0] quotient;
  wire  [31:0] remainder;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  iter_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // MIPS DIV/DIVU semantics from plain arithmetic (64-bit, truncating toward zero)
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
    int     sa, sb;
    longint la, lb, lq, lr;
    dz  = 1'b0;
    lat = 33;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      if (FAST) begin
        dz  = 1'b1;
        lat = 1;
      end else if (s && a[31]) begin
        q = 32'd1;  // negated all-ones magnitude quotient; remainder -|a| == a
      end
    end else if (s) begin
      sa = a; sb = b;
      la = sa; lb = sb;
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input int inject_at);
    logic [31:0] eq, er;
    logic        ez;
    int          lat, cyc, nbusy;
    ref_div(a, b, s, eq, er, ez, lat);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
    cyc = 0; nbusy = 0;
    check({tag, " held_q"}, quotient, last_q);
    check({tag, " held_r"}, remainder, last_r);
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) nbusy++;
      start = (cyc == inject_at);
      if (start) begin
        is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, cyc, lat);
    check({tag, " busy_cycles"}, nbusy, lat);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int ndone;
    logic [31:0] a, b;
    bit s;

    // Reset dominates a held start
    rst = 1'b0; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    repeat (2) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst div_zero", {31'd0, div_zero}, 32'd0);
    rst = 1'b1; start = 1'b0;

    run_op("divu_100_7", 32'd100, 32'd7, 1'b0, -1);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, -1);
    run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, -1);
    run_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10);
    run_op("divu_zero", 32'h0000_1234, 32'd0, 1'b0, -1);
    run_op("div_neg_zero", 32'hFFFF_FF00, 32'd0, 1'b1, -1);
    run_op("divu_max", 32'hFFFF_FFFF, 32'd1, 1'b0, -1);

    // Reset in the middle of a DIVU: operation aborts, no done
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd999; divisor = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midrst no_done", ndone, 32'd0);
    last_q = '0;
    last_r = '0;
    run_op("after_rst", 32'd12345, 32'd67, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = -$urandom_range(1, 16);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op($sformatf("rnd%0d", i), a, b, s, ($urandom_range(0, 3) == 0) ? 5 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
